// File: rtl/abs_diff_ctrl_pkg.sv
// abs_diff_ctrl_pkg: shared FSM encoding and default width for the abs-diff controller.
package abs_diff_ctrl_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, SUB, NEG, HOLD} state_t;
endpackage

// File: rtl/abs_diff_ctrl_rca_diff.sv
// rca_diff: fixed 8-bit ripple-carry subtractor, sum = a + ~b + cin.
module rca_diff (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;
    assign c[0] = cin;
    assign cout = c[8];
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = a[i] ^ ~b[i] ^ c[i];
        assign c[i + 1] = (a[i] & ~b[i]) | (a[i] & c[i]) | (~b[i] & c[i]);
    end
endmodule

// File: rtl/abs_diff_ctrl.sv
// abs_diff_ctrl: two-requester round-robin front end sharing one subtractor for |a-b|.
module abs_diff_ctrl
    import abs_diff_ctrl_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter bit ABS_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_diff,
    output logic             rsp_neg,
    output logic             busy
);
    state_t state, nxt;
    logic last_grant, gnt, accept, id, neg, cout;
    logic [WIDTH-1:0] op_a, op_b, diff, sa, sb, sum;

    rca_diff u_rca (.a(sa), .b(sb), .cin(1'b1), .sum(sum), .cout(cout));

    always_comb begin
        gnt        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        accept     = rst_n & (state == IDLE) & (req0_valid | req1_valid);
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        // negate pass reuses the subtractor as 0 - diff
        sa         = (state == NEG) ? '0 : op_a;
        sb         = (state == NEG) ? diff : op_b;
        nxt        = (state == IDLE) ? (accept ? SUB : IDLE) :
                     (state == SUB)  ? ((!cout && ABS_EN) ? NEG : HOLD) :
                     (state == NEG)  ? HOLD :
                     (rsp_ready ? IDLE : HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            diff       <= '0;
            id         <= 1'b0;
            neg        <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_a       <= gnt ? req1_a : req0_a;
                op_b       <= gnt ? req1_b : req0_b;
                id         <= gnt;
                last_grant <= gnt;
            end
            if (state == SUB) begin
                diff <= sum;
                neg  <= ~cout;
            end
            if (state == NEG) diff <= sum;
        end
    end

    assign rsp_valid = (state == HOLD);
    assign rsp_id    = id;
    assign rsp_diff  = diff;
    assign rsp_neg   = neg;
    assign busy      = (state != IDLE);
endmodule
